// File: rtl/wb_register_file.sv
// Write-back stage: selects the write-back value, commits it to a 32-entry register file
// with R0 hardwired to zero, and serves two combinational read ports with write-first bypass.
module wb_register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int BYPASS = 1
) (
   input  logic              Clk_in,
   input  logic              Rst,
   input  logic              MemtoReg_in,
   input  logic              RegWrite_in,
   input  logic [DATA_W-1:0] ALUResult_in,
   input  logic [DATA_W-1:0] ReadData_in,
   input  logic [ADDR_W-1:0] WriteReg_in,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1_out,
   output logic [DATA_W-1:0] ReadData2_out,
   output logic [DATA_W-1:0] WriteData_out,
   output logic [31:0]       WriteCount_out
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [31:0]       write_count_q;
   logic [31:0]       write_count_d;
   logic [DATA_W-1:0] write_data;
   logic              commit;
   logic [ADDR_W-1:0] rd_addr [2];

   assign write_data = MemtoReg_in ? ReadData_in : ALUResult_in;
   assign commit     = RegWrite_in & ~Rst & (WriteReg_in != '0);

   always_comb begin
      write_count_d = write_count_q;
      if (commit) begin
         write_count_d = write_count_q + 32'd1;
      end
   end

   // Entry 0 is cleared on reset and never written, so it always reads back zero.
   always_ff @(posedge Clk_in) begin
      if (Rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         write_count_q <= '0;
      end else begin
         if (commit) begin
            regs_q[WriteReg_in] <= write_data;
         end
         write_count_q <= write_count_d;
      end
   end

   assign rd_addr[0] = ReadReg1;
   assign rd_addr[1] = ReadReg2;

   // Index 0 and reset take priority over the bypass path.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [DATA_W-1:0] rdata;
      always_comb begin
         rdata = regs_q[rd_addr[gi]];
         if (Rst || (rd_addr[gi] == '0)) begin
            rdata = '0;
         end else if ((BYPASS != 0) && commit && (rd_addr[gi] == WriteReg_in)) begin
            rdata = write_data;
         end
      end
   end

   assign ReadData1_out  = g_rd[0].rdata;
   assign ReadData2_out  = g_rd[1].rdata;
   assign WriteData_out  = write_data;
   assign WriteCount_out = write_count_q;

endmodule
